acc_vec_engine: RTL
===================

ACC_VEC_ENGINE -- requirements
Module: acc_vec_engine

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 256, meaning the number of 32-bit operand/result words; fixed at 256 to match the port arrays.
REQ-002 SHALL have parameter WORDS_PER_CYCLE, default 4, meaning words processed per RUN cycle; legal values 1, 2, 4, 8, each dividing NUM_WORDS.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn_i, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, the run request level from the memory-mapped wrapper; a rising edge requests a run.
REQ-006 SHALL have port op_i, input, 2, the lane operation select, sampled on the trigger edge.
REQ-007 SHALL have port acc_in_A, input, [3:0][7:0] x [255:0], the operand A words.
REQ-008 SHALL have port acc_in_B, input, [3:0][7:0] x [255:0], the operand B words.
REQ-009 SHALL have port acc_out, output, [3:0][7:0] x [255:0], the registered result words.
REQ-010 SHALL have port busy_o, output, 1, high while in RUN.
REQ-011 SHALL have port done_o, output, 1, a one-cycle completion pulse.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE, plus a registered start_q and a word index idx of width clog2(NUM_WORDS)+1 bits.
REQ-013 SHALL define trigger = start & ~start_q & (state==IDLE); start_q SHALL load start every cycle in every state.
REQ-014 On a trigger edge, the block SHALL latch op_i into op_q, clear idx to 0 and enter RUN.
REQ-015 In RUN, each edge SHALL write acc_out[idx+j] = f(acc_in_A[idx+j], acc_in_B[idx+j]) for j = 0..WORDS_PER_CYCLE-1 and SHALL advance idx by WORDS_PER_CYCLE.
REQ-016 f SHALL be applied per byte lane b = 0..3, independently, with unsigned 8-bit operands: op 00 = (a+b) mod 256; op 01 = min(a+b,255); op 10 = low 8 bits of a*b; op 11 = |a-b|.
REQ-017 The RUN edge that writes idx = NUM_WORDS-WORDS_PER_CYCLE SHALL move to DONE; RUN lasts exactly NUM_WORDS/WORDS_PER_CYCLE cycles (64 at default).
REQ-018 DONE SHALL last one cycle with done_o=1 and busy_o=0, then return to IDLE.
REQ-019 busy_o SHALL be 1 exactly when state==RUN; done_o SHALL be 1 exactly when state==DONE.
REQ-020 Rising edges of start during RUN or DONE SHALL be ignored (not queued); start held high SHALL trigger only once.
REQ-021 acc_out words not yet written in the current run SHALL hold their previous values; all acc_out words SHALL hold in IDLE and DONE.
REQ-022 Operands SHALL be read live at the edge that writes each chunk; changes to already-processed words SHALL not affect acc_out.
REQ-023 op_i changes during RUN SHALL have no effect; op_q is used for the whole run.

Reset
REQ-024 While rstn_i=0, state SHALL be IDLE, idx=0, op_q=00, busy_o=0, done_o=0, every acc_out byte 0x00, and start_q=1.
REQ-025 Because start_q resets to 1, start held high across reset release SHALL NOT trigger; a low-then-high transition is required.
REQ-026 Reset asserted mid-RUN SHALL immediately abort, zero acc_out and return to IDLE, with no done_o pulse.

Verification
REQ-027 Default params, op=00, A[i]=0x01010101*i, B[i]=0x02020202, start rises -> busy_o high for 64 cycles, done_o high for exactly 1 cycle after that, and acc_out[i] bytes = (i+2) mod 256.
REQ-028 op=01, A bytes 0xF0, B bytes 0x20 -> all result bytes 0xFF; op=10, A=0x10, B=0x11 -> 0x10; op=11, A=0x05, B=0x09 -> 0x04.
REQ-029 Start held high for 200 cycles -> exactly one run and one done_o pulse; a second rising edge issued during RUN -> no second run.
REQ-030 Start high at reset release -> no run; start dropped low then raised -> run begins on the edge after the rise.
REQ-031 rstn_i pulsed low at RUN cycle 20 -> busy_o=0 and all acc_out=0 immediately, no done_o; a new start then completes normally.
REQ-032 WORDS_PER_CYCLE=1 build -> RUN lasts 256 cycles; acc_out[k] changes on the (k+1)th edge after trigger while acc_out[k+1] still holds its old value.

Source files
------------

// File: rtl/acc_vec_engine.sv
// acc_vec_engine: streams a bytewise lane operation over NUM_WORDS operand
// word pairs, WORDS_PER_CYCLE words per clock, into a registered result array.
// A rising edge on start (seen only in IDLE) launches one pass; busy_o covers
// the pass and done_o pulses for one cycle at its end.
module acc_vec_engine #(
  parameter int unsigned NUM_WORDS       = 256,
  parameter int unsigned WORDS_PER_CYCLE = 4
) (
  input  logic            clk,
  input  logic            rstn_i,
  input  logic            start,
  input  logic [1:0]      op_i,
  input  logic [3:0][7:0] acc_in_A [NUM_WORDS-1:0],
  input  logic [3:0][7:0] acc_in_B [NUM_WORDS-1:0],
  output logic [3:0][7:0] acc_out  [NUM_WORDS-1:0],
  output logic            busy_o,
  output logic            done_o
);

  localparam int unsigned ADDR_W = $clog2(NUM_WORDS);
  localparam int unsigned IDX_W  = ADDR_W + 1;

  // idx value of the final chunk of a pass, and the per-cycle advance
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - WORDS_PER_CYCLE);
  localparam logic [IDX_W-1:0] STEP     = IDX_W'(WORDS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             start_q;
  logic [1:0]       op_q;
  logic [IDX_W-1:0] idx;
  logic             trigger;
  logic             last_chunk;

  logic [ADDR_W-1:0] chunk_addr [WORDS_PER_CYCLE];
  logic [3:0][7:0]   chunk_res  [WORDS_PER_CYCLE];

  // Per-lane operation on unsigned bytes
  function automatic logic [7:0] lane_op(input logic [1:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
    logic [8:0]  sum;
    logic [15:0] prod;
    logic [7:0]  res;
    sum  = {1'b0, a} + {1'b0, b};
    prod = {8'd0, a} * {8'd0, b};
    res  = '0;
    case (op)
      2'b00:   res = sum[7:0];
      2'b01:   res = sum[8] ? 8'hFF : sum[7:0];
      2'b10:   res = prod[7:0];
      2'b11:   res = (a >= b) ? (a - b) : (b - a);
      default: res = '0;
    endcase
    return res;
  endfunction

  // Edge detect is gated by IDLE so edges during RUN/DONE are dropped, not queued
  assign trigger    = start & ~start_q & (state == IDLE);
  assign last_chunk = (idx == LAST_IDX);

  assign busy_o = (state == RUN);
  assign done_o = (state == DONE);

  // State register
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger) state_nxt = RUN;
      RUN:     if (last_chunk) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Start edge history, latched operation and word index
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      // start_q resets high so a start level held through reset is not an edge
      start_q <= 1'b1;
      op_q    <= '0;
      idx     <= '0;
    end else begin
      start_q <= start;
      if (trigger) begin
        op_q <= op_i;
        idx  <= '0;
      end else if (state == RUN) begin
        idx <= idx + STEP;
      end
    end
  end

  // Word addresses of the chunk being processed this cycle
  always_comb begin
    for (int unsigned j = 0; j < WORDS_PER_CYCLE; j++) begin
      chunk_addr[j] = idx[ADDR_W-1:0] + ADDR_W'(j);
    end
  end

  // Lane results for the current chunk, from live operands
  always_comb begin
    for (int unsigned j = 0; j < WORDS_PER_CYCLE; j++) begin
      for (int unsigned b = 0; b < 4; b++) begin
        chunk_res[j][b] = lane_op(op_q, acc_in_A[chunk_addr[j]][b],
                                  acc_in_B[chunk_addr[j]][b]);
      end
    end
  end

  // Result array: cleared by reset, written one chunk per RUN cycle, else held
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned w = 0; w < NUM_WORDS; w++) begin
        acc_out[w] <= '0;
      end
    end else if (state == RUN) begin
      for (int unsigned j = 0; j < WORDS_PER_CYCLE; j++) begin
        acc_out[chunk_addr[j]] <= chunk_res[j];
      end
    end
  end

endmodule
